// File: rtl/uart_csr_bridge.sv
// UART-to-CSR debug bridge. It receives 8N1 command frames, issues single-word
// CSR reads and writes, and sends the response bytes back on the serial line.
module uart_csr_bridge #(
    parameter int clk_freq       = 100000000,
    parameter int baud           = 115200,
    parameter int timeout_cycles = clk_freq / 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [13:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_di,
    input  logic [31:0] csr_do,
    output logic        busy
);
    localparam int DIV_RAW = clk_freq / baud / 16;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [31:0] TO_LAST = 32'(timeout_cycles - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        P_IDLE, P_ADDR_H, P_ADDR_L, P_DATA, P_WRITE, P_READ, P_READ_WAIT, P_RESP
    } p_state_t;

    logic [DW-1:0] div_cnt_r;
    logic          tick_r;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic          rx_fall_s;
    rx_state_t     rx_state_r;
    logic [3:0]    rx_tcnt_r;
    logic [2:0]    rx_bcnt_r;
    logic [7:0]    rx_shift_r, rx_byte_r;
    logic          rx_valid_r;
    logic [8:0]    tx_shift_r;
    logic [3:0]    tx_tcnt_r, tx_bcnt_r;
    logic          tx_idle_r;
    logic          tx_ready_s, tx_load_s;
    logic [7:0]    tx_byte_s;
    p_state_t      p_state_r;
    logic          is_write_r;
    logic [5:0]    a_hi_r;
    logic [1:0]    d_cnt_r;
    logic [31:0]   resp_r;
    logic [2:0]    resp_left_r;
    logic [31:0]   to_cnt_r;
    logic          to_hit_s;

    assign rx_fall_s  = rx_prev_r & ~rx_sync_r;
    assign tx_byte_s  = resp_r[31:24];
    assign to_hit_s   = (to_cnt_r >= TO_LAST);
    // The transmitter accepts a new byte on the very cycle its stop bit ends,
    // so response frames follow each other with no idle gap.
    assign tx_ready_s = tx_idle_r | (tick_r & (tx_tcnt_r == 4'd15) & (tx_bcnt_r == 4'd9));

    // 16x oversampling tick generator
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_r <= {DW{1'b0}};
            tick_r    <= 1'b0;
        end else if (div_cnt_r == {DW{1'b0}}) begin
            div_cnt_r <= DW'(DIV - 1);
            tick_r    <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r - DW'(1);
            tick_r    <= 1'b0;
        end
    end

    // Two-flop synchronizer for uart_rx plus edge-detect history
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver: mid-bit sampling, glitch rejection and framing check
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state_r <= RX_IDLE;
            rx_tcnt_r  <= 4'd0;
            rx_bcnt_r  <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_fall_s) begin
                        rx_tcnt_r  <= 4'd0;
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick_r) begin
                        if (rx_tcnt_r == 4'd7) begin
                            rx_tcnt_r  <= 4'd0;
                            rx_bcnt_r  <= 3'd0;
                            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tcnt_r <= rx_tcnt_r + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick_r) begin
                        rx_tcnt_r <= rx_tcnt_r + 4'd1;
                        if (rx_tcnt_r == 4'd15) begin
                            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                            rx_bcnt_r  <= rx_bcnt_r + 3'd1;
                            if (rx_bcnt_r == 3'd7) begin
                                rx_state_r <= RX_STOP;
                            end
                        end
                    end
                end
                RX_STOP: begin
                    if (tick_r) begin
                        rx_tcnt_r <= rx_tcnt_r + 4'd1;
                        if (rx_tcnt_r == 4'd15) begin
                            if (rx_sync_r) begin
                                rx_byte_r  <= rx_shift_r;
                                rx_valid_r <= 1'b1;
                            end
                            rx_state_r <= RX_IDLE;
                        end
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Transmitter shift register; async reset returns the line to idle at once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_tx    <= 1'b1;
            tx_idle_r  <= 1'b1;
            tx_shift_r <= 9'h1FF;
            tx_tcnt_r  <= 4'd0;
            tx_bcnt_r  <= 4'd0;
        end else if (tx_load_s) begin
            uart_tx    <= 1'b0;
            tx_idle_r  <= 1'b0;
            tx_shift_r <= {1'b1, tx_byte_s};
            tx_tcnt_r  <= 4'd0;
            tx_bcnt_r  <= 4'd0;
        end else if (!tx_idle_r && tick_r) begin
            tx_tcnt_r <= tx_tcnt_r + 4'd1;
            if (tx_tcnt_r == 4'd15) begin
                if (tx_bcnt_r == 4'd9) begin
                    tx_idle_r <= 1'b1;
                end else begin
                    uart_tx    <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                    tx_bcnt_r  <= tx_bcnt_r + 4'd1;
                end
            end
        end
    end

    // Response byte hand-off to the transmitter
    always_comb begin
        tx_load_s = 1'b0;
        if ((p_state_r == P_RESP) && (resp_left_r != 3'd0) && tx_ready_s) begin
            tx_load_s = 1'b1;
        end else begin
            tx_load_s = 1'b0;
        end
    end

    // Command parser and CSR bus initiator
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            p_state_r   <= P_IDLE;
            is_write_r  <= 1'b0;
            a_hi_r      <= 6'd0;
            d_cnt_r     <= 2'd0;
            resp_r      <= 32'h0;
            resp_left_r <= 3'd0;
            to_cnt_r    <= 32'd0;
            csr_a       <= 14'h0;
            csr_we      <= 1'b0;
            csr_di      <= 32'h0;
            busy        <= 1'b0;
        end else begin
            csr_we <= 1'b0;
            case (p_state_r)
                P_IDLE: begin
                    to_cnt_r <= 32'd0;
                    if (rx_valid_r && ((rx_byte_r == 8'h01) || (rx_byte_r == 8'h02))) begin
                        is_write_r <= (rx_byte_r == 8'h01);
                        p_state_r  <= P_ADDR_H;
                        busy       <= 1'b1;
                    end
                end
                P_ADDR_H: begin
                    if (rx_valid_r) begin
                        a_hi_r    <= rx_byte_r[5:0];
                        to_cnt_r  <= 32'd0;
                        p_state_r <= P_ADDR_L;
                    end else if (to_hit_s) begin
                        p_state_r <= P_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                    end
                end
                P_ADDR_L: begin
                    if (rx_valid_r) begin
                        csr_a     <= {a_hi_r, rx_byte_r};
                        d_cnt_r   <= 2'd0;
                        to_cnt_r  <= 32'd0;
                        p_state_r <= is_write_r ? P_DATA : P_READ;
                    end else if (to_hit_s) begin
                        p_state_r <= P_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                    end
                end
                P_DATA: begin
                    if (rx_valid_r) begin
                        csr_di   <= {csr_di[23:0], rx_byte_r};
                        d_cnt_r  <= d_cnt_r + 2'd1;
                        to_cnt_r <= 32'd0;
                        if (d_cnt_r == 2'd3) begin
                            csr_we    <= 1'b1;
                            p_state_r <= P_WRITE;
                        end
                    end else if (to_hit_s) begin
                        p_state_r <= P_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                    end
                end
                P_WRITE: begin
                    resp_r      <= {8'hAA, 24'h000000};
                    resp_left_r <= 3'd1;
                    p_state_r   <= P_RESP;
                end
                P_READ: begin
                    p_state_r <= P_READ_WAIT;
                end
                P_READ_WAIT: begin
                    resp_r      <= csr_do;
                    resp_left_r <= 3'd4;
                    p_state_r   <= P_RESP;
                end
                P_RESP: begin
                    if (tx_load_s) begin
                        resp_r      <= {resp_r[23:0], 8'h00};
                        resp_left_r <= resp_left_r - 3'd1;
                    end else if ((resp_left_r == 3'd0) && tx_idle_r) begin
                        p_state_r <= P_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    p_state_r <= P_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_csr_bridge.sv
// Directed bench for uart_csr_bridge: table of command vectors plus
// hand-written framing, glitch, timeout and reset sequences.
module tb_uart_csr_bridge;
    localparam int BIT = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        tx;
    logic [13:0] a;
    logic        we;
    logic [31:0] di;
    logic [31:0] csr_do;
    logic        busy;

    uart_csr_bridge #(.clk_freq(1600000), .baud(100000), .timeout_cycles(1000)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_rx(rx), .uart_tx(tx),
        .csr_a(a), .csr_we(we), .csr_di(di), .csr_do(csr_do), .busy(busy)
    );

    always #5 clk = ~clk;

    // Responder: read data appears the cycle after the address
    always @(posedge clk) begin
        case (a)
            14'h3004: csr_do <= 32'h12345678;
            14'h3FFF: csr_do <= 32'hCAFEF00D;
            14'h0008: csr_do <= 32'h0BADC0DE;
            default:  csr_do <= 32'h00000000;
        endcase
    end

    int          cyc      = 0;
    int          we_cyc   = 0;
    int          busy_cyc = 0;
    logic [13:0] we_a;
    logic [31:0] we_d;
    logic [7:0]  rq[$];
    int          tq[$];
    int          nvec = 0;
    int          nerr = 0;

    always @(negedge clk) begin
        cyc++;
        if (we === 1'b1) begin
            we_cyc++;
            we_a = a;
            we_d = di;
        end
        if (busy === 1'b1) busy_cyc++;
    end

    // Serial decoder for uart_tx: records each byte and its start-bit cycle
    initial begin : tx_mon
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                tq.push_back(cyc);
                repeat (8) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                rq.push_back(b);
            end
            prev = tx;
        end
    end

    typedef struct {
        logic [55:0] cmd;
        int          n;
        logic        is_wr;
        logic [13:0] exp_a;
        logic [31:0] exp_d;
        int          nresp;
        logic [31:0] resp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rb, wb, t, got;
        rb = rq.size();
        wb = we_cyc;
        for (int i = 0; i < v.n; i++) send_byte(v.cmd[55-8*i -: 8], 1'b1);
        t = 0;
        while ((rq.size() - rb) < v.nresp && t < 1000) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (200) @(negedge clk);
        got = rq.size() - rb;
        chk({tag, " resp_count"}, 32'(got), 32'(v.nresp));
        for (int i = 0; i < v.nresp && i < got; i++)
            chk({tag, " resp_byte"}, 32'(rq[rb+i]), 32'(v.resp[31-8*i -: 8]));
        for (int i = 1; i < got; i++)
            chk({tag, " frame_gap"}, 32'(tq[rb+i] - tq[rb+i-1]), 32'd160);
        chk({tag, " we_cycles"}, 32'(we_cyc - wb), v.is_wr ? 32'd1 : 32'd0);
        if (v.is_wr) begin
            chk({tag, " we_addr"}, 32'(we_a), 32'(v.exp_a));
            chk({tag, " we_data"}, we_d, v.exp_d);
        end
        chk({tag, " csr_a"}, 32'(a), 32'(v.exp_a));
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin : main
        int t, bb;
        vecs[0] = '{56'h010C02DEADBEEF, 7, 1'b1, 14'h0C02, 32'hDEADBEEF, 1, 32'hAA000000};
        vecs[1] = '{56'h02300400000000, 3, 1'b0, 14'h3004, 32'h00000000, 4, 32'h12345678};
        vecs[2] = '{56'h01C1230000005A, 7, 1'b1, 14'h0123, 32'h0000005A, 1, 32'hAA000000};
        vecs[3] = '{56'h5502FFFF000000, 4, 1'b0, 14'h3FFF, 32'h00000000, 4, 32'hCAFEF00D};
        vecs[4] = '{56'h02000800000000, 3, 1'b0, 14'h0008, 32'h00000000, 4, 32'h0BADC0DE};

        repeat (3) @(negedge clk);
        chk("reset uart_tx", 32'(tx), 32'd1);
        chk("reset csr_a", 32'(a), 32'd0);
        chk("reset csr_we", 32'(we), 32'd0);
        chk("reset csr_di", di, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Unknown command byte must not leave IDLE
        bb = busy_cyc;
        send_byte(8'h55, 1'b1);
        repeat (40) @(negedge clk);
        chk("badcmd busy_cycles", 32'(busy_cyc - bb), 32'd0);

        // Framing error: 0x02 with a low stop bit is discarded
        bb = busy_cyc;
        send_byte(8'h02, 1'b0);
        repeat (40) @(negedge clk);
        chk("framing busy_cycles", 32'(busy_cyc - bb), 32'd0);
        run_vec(vecs[4], "after_framing");

        // Short glitch just before a real command must not misalign the receiver
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        run_vec(vecs[1], "after_glitch");

        // Partial write abandoned by the inter-byte timeout
        bb = we_cyc;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (1200) @(negedge clk);
        chk("timeout busy", 32'(busy), 32'd0);
        chk("timeout we_cycles", 32'(we_cyc - bb), 32'd0);
        run_vec(vecs[4], "after_timeout");

        // Asynchronous reset during the second response byte
        bb = rq.size();
        send_byte(8'h02, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'h04, 1'b1);
        t = 0;
        while (rq.size() - bb < 1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (tx !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("second byte start seen", 32'(tx), 32'd0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset uart_tx", 32'(tx), 32'd1);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset csr_a", 32'(a), 32'd0);
        chk("async reset csr_we", 32'(we), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        run_vec(vecs[0], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/uart_csr_bridge.md
# uart_csr_bridge

UART-to-CSR debug bridge: receives framed command bytes on an 8N1 serial line and acts as the initiator on the system CSR bus. It issues single-word reads and writes to any CSR responder and returns read data or a write acknowledge over the serial line. It sits beside the CPU as an alternative CSR master for board bring-up and host-side register access.

## Interface
- clk_freq, 100000000, system clock frequency in Hz
- baud, 115200, serial bit rate; divisor = clk_freq/baud/16 (16x oversampling tick), fixed at elaboration, minimum 1
- timeout_cycles, clk_freq/10, idle cycles between received bytes after which a partial command is abandoned
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  asynchronous, active-low reset
- uart_rx  input  1  serial input, asynchronous to sys_clk, idle high
- uart_tx  output  1  serial output, idle high
- csr_a  output  14  CSR address
- csr_we  output  1  CSR write strobe, one cycle per write
- csr_di  output  32  CSR write data
- csr_do  input  32  OR of all responder read data; valid the cycle after csr_a is presented
- busy  output  1  high while a command is being parsed, executed or answered

## Operation
- Reset values: uart_tx=1, csr_a=0, csr_we=0, csr_di=0, busy=0; all FSMs idle, counters cleared.
- uart_rx goes through a 2-flop synchronizer before use.
- Tick generator: counter reloads at divisor-1 and pulses tick for one cycle on reload.
- Receiver: idle until a synchronized falling edge; the start bit is resampled after 8 ticks, and if it reads high the receiver returns to idle (glitch). Data bits 0..7 are then sampled LSB first every 16 ticks, followed by the stop bit. If the stop bit is 1, rx_byte is captured and rx_valid pulses for one cycle. If the stop bit is 0 (framing error), the byte is discarded.
- Transmitter: on a load with a byte, emits start(0), 8 data bits LSB first and stop(1), each 16 ticks long. tx_idle is high when not shifting.
- Command format (bytes, MSB first):
  - Write: 0x01, A_hi, A_lo, D3, D2, D1, D0.
  - Read: 0x02, A_hi, A_lo.
  - csr_a = {A_hi[5:0], A_lo}; A_hi[7:6] are ignored.
- Parser FSM:
  - IDLE: rx 0x01 -> ADDR_H (write), 0x02 -> ADDR_H (read); any other byte is dropped and the FSM stays in IDLE.
  - ADDR_H -> ADDR_L on the next byte.
  - ADDR_L -> DATA (write) or READ (read).
  - DATA: 2-bit counter, shifts 4 bytes into csr_di; on the 4th byte -> WRITE.
  - WRITE: csr_we=1 for exactly one cycle with csr_a/csr_di stable; queue ack byte 0xAA; -> RESP.
  - READ: drive csr_a, one cycle -> READ_WAIT.
  - READ_WAIT: capture csr_do into the response shift register; queue 4 bytes; -> RESP.
  - RESP: load the transmitter with each queued byte MSB first whenever tx_idle; after the last stop bit completes -> IDLE.
- busy=1 in every state except IDLE.
- Bytes received while in READ, READ_WAIT, WRITE or RESP are dropped; the host must wait for the full response.
- Timeout: an inter-byte counter runs in ADDR_H, ADDR_L and DATA and is cleared on each rx_valid. Reaching timeout_cycles returns the FSM to IDLE with no CSR access. The counter is inactive in IDLE and RESP.
- csr_a and csr_di hold their last value when not accessing; csr_we is low outside WRITE.
- Asynchronous reset at any point aborts the current command. uart_tx is forced to 1 immediately, without waiting for a clock.

## Timing
- One bit = 16*divisor cycles; one frame = 160*divisor cycles.
- Last received byte's rx_valid -> csr_we high: 1 cycle (the WRITE state).
- READ entry -> csr_do captured: 2 cycles.
- Capture -> start bit of first response byte: at most 2 cycles.
- Response bytes are back-to-back with no idle bits between frames.
- rx_valid is registered one cycle after the stop-bit sample.
- The receiver keeps operating during RESP (frames are tracked, bytes dropped), so it stays aligned.

## Test plan
Bench parameters: clk_freq=1600000, baud=100000 (divisor 1, 16 cycles/bit), timeout_cycles=1000.
- Write: send 0x01,0x0C,0x02,0xDE,0xAD,0xBE,0xEF -> exactly one csr_we pulse with csr_a=14'h0C02 and csr_di=32'hDEADBEEF, then uart_tx frame 0xAA, busy low after its stop bit.
- Read: send 0x02,0x30,0x04; the responder model returns 32'h12345678 one cycle after csr_a=14'h3004 -> uart_tx frames 0x12,0x34,0x56,0x78 back-to-back, csr_we never asserted.
- Address masking / bad command: send 0x55, then read 0xFF,0xFF -> 0x55 is ignored (busy stays 0), and the read is issued with csr_a=14'h3FFF.
- Timeout: send 0x01,0x00, idle 1200 cycles, then a read 0x02,0x00,0x08 -> no csr_we at any time, and the read of 14'h0008 completes with 4 response bytes.
- Framing and glitch: a frame with stop bit 0 -> no rx_valid and the FSM stays idle; a 3-cycle low pulse on uart_rx -> ignored.
- Reset mid-response: assert sys_rst_n low during the second read response byte -> uart_tx=1 and busy=0 asynchronously; after release, a new write command works normally.
